// File: rtl/vc_pkg.sv
// vc_pkg: shared types, states and default widths for the victim cache.
package vc_pkg;
  localparam int VC_ENTRIES_DEF = 4;
  localparam int LINE_W = 128;
  localparam int LINE_AW = 28;
  typedef struct packed {
    logic valid;
    logic dirty;
    logic [LINE_AW-1:0] line_addr;
    logic [LINE_W-1:0] data;
  } vc_entry_s;
  typedef enum logic [2:0] {IDLE, WB_WAIT, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE} vc_state_e;
endpackage

// File: rtl/vc_match_sel.sv
// vc_match_sel: lowest-index address match and lowest-index free slot finder.
module vc_match_sel import vc_pkg::*; #(
  parameter int N = VC_ENTRIES_DEF,
  parameter int AW = LINE_AW,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]         valid_i,
  input  logic [N-1:0][AW-1:0] addr_i,
  input  logic [AW-1:0]        key_i,
  output logic                 hit_o,
  output logic [IW-1:0]        hit_idx_o,
  output logic                 free_found_o,
  output logic [IW-1:0]        free_idx_o
);
  always_comb begin
    hit_o = 1'b0;
    hit_idx_o = '0;
    free_found_o = 1'b0;
    free_idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_i[i] && addr_i[i] == key_i) begin
        hit_o = 1'b1;
        hit_idx_o = IW'(i);
      end
      if (!valid_i[i]) begin
        free_found_o = 1'b1;
        free_idx_o = IW'(i);
      end
    end
  end
endmodule

// File: rtl/victim_cache_assoc.sv
// victim_cache_assoc: fully-associative victim cache with FIFO replacement,
// extract-on-hit and a valid/ready writeback path for dirty lines.
module victim_cache_assoc import vc_pkg::*; #(
  parameter int VC_ENTRIES = VC_ENTRIES_DEF,
  parameter int LINE_WIDTH = LINE_W,
  parameter int LINE_ADDR_WIDTH = LINE_AW,
  localparam int IW = $clog2(VC_ENTRIES),
  localparam int OW = IW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lookup_req_i,
  input  logic [LINE_ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                       lookup_valid_o,
  output logic                       lookup_hit_o,
  output logic                       lookup_dirty_o,
  output logic [LINE_WIDTH-1:0]      lookup_data_o,
  input  logic                       extract_i,
  input  logic                       insert_valid_i,
  output logic                       insert_ready_o,
  input  logic [LINE_ADDR_WIDTH-1:0] insert_addr_i,
  input  logic [LINE_WIDTH-1:0]      insert_data_i,
  input  logic                       insert_dirty_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [LINE_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [LINE_WIDTH-1:0]      wb_data_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic [OW-1:0]              occupancy_o
);
  localparam logic [IW-1:0] LAST = IW'(VC_ENTRIES - 1);
  vc_state_e state_q, state_d;
  logic [VC_ENTRIES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [VC_ENTRIES-1:0][LINE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [VC_ENTRIES-1:0][LINE_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, lk_idx_q, lk_idx, ins_hit_idx, ins_free_idx, tgt;
  logic wb_valid_q, wb_valid_d, lk_valid_q, lk_hit_q, lk_dirty_q, lk_hit, ins_hit, ins_free, ext, ins;
  logic [LINE_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [LINE_WIDTH-1:0] wb_data_q, wb_data_d, lk_data_q;
  logic lk_free_unused;
  logic [IW-1:0] lk_fidx_unused;
  logic [OW-1:0] occ;
  logic [VC_ENTRIES-1:0] valid_x;
  vc_match_sel #(.N(VC_ENTRIES), .AW(LINE_ADDR_WIDTH)) u_lk_sel (
    .valid_i(valid_q), .addr_i(addr_q), .key_i(lookup_addr_i),
    .hit_o(lk_hit), .hit_idx_o(lk_idx),
    .free_found_o(lk_free_unused), .free_idx_o(lk_fidx_unused)
  );
  // The insert search sees the extract of the same cycle already applied.
  assign ext = extract_i & lk_valid_q & lk_hit_q;
  always_comb begin
    valid_x = valid_q;
    if (ext) valid_x[lk_idx_q] = 1'b0;
  end
  vc_match_sel #(.N(VC_ENTRIES), .AW(LINE_ADDR_WIDTH)) u_ins_sel (
    .valid_i(valid_x), .addr_i(addr_q), .key_i(insert_addr_i),
    .hit_o(ins_hit), .hit_idx_o(ins_hit_idx),
    .free_found_o(ins_free), .free_idx_o(ins_free_idx)
  );
  assign insert_ready_o = (state_q == IDLE) & ~wb_valid_q & ~flush_i;
  assign ins = insert_valid_i & insert_ready_o;
  assign tgt = ins_hit ? ins_hit_idx : ins_free ? ins_free_idx : ptr_q;
  always_comb begin
    occ = '0;
    for (int i = 0; i < VC_ENTRIES; i++) occ = occ + OW'(valid_q[i]);
  end
  always_comb begin
    state_d = state_q;
    valid_d = valid_x;
    dirty_d = dirty_q;
    addr_d = addr_q;
    data_d = data_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (ext) dirty_d[lk_idx_q] = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH_SCAN;
          idx_d = '0;
        end else if (ins) begin
          if (!ins_hit && !ins_free) begin
            ptr_d = ptr_q + 1'b1;
            if (dirty_d[ptr_q]) begin
              wb_valid_d = 1'b1;
              wb_addr_d = addr_q[ptr_q];
              wb_data_d = data_q[ptr_q];
              state_d = WB_WAIT;
            end
          end
          dirty_d[tgt] = (ins_hit & dirty_d[tgt]) | insert_dirty_i;
          valid_d[tgt] = 1'b1;
          addr_d[tgt] = insert_addr_i;
          data_d[tgt] = insert_data_i;
        end
      end
      WB_WAIT: begin
        if (wb_ready_i) begin
          wb_valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      FLUSH_SCAN: begin
        if (valid_d[idx_q] && dirty_d[idx_q]) begin
          wb_valid_d = 1'b1;
          wb_addr_d = addr_q[idx_q];
          wb_data_d = data_q[idx_q];
          dirty_d[idx_q] = 1'b0;
          state_d = FLUSH_WB;
        end else if (idx_q == LAST) begin
          valid_d = '0;
          dirty_d = '0;
          ptr_d = '0;
          state_d = FLUSH_DONE;
        end else idx_d = idx_q + 1'b1;
      end
      FLUSH_WB: begin
        if (wb_ready_i) begin
          wb_valid_d = 1'b0;
          if (idx_q == LAST) begin
            valid_d = '0;
            dirty_d = '0;
            ptr_d = '0;
            state_d = FLUSH_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            state_d = FLUSH_SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      ptr_q <= '0;
      idx_q <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      lk_valid_q <= 1'b0;
      lk_hit_q <= 1'b0;
      lk_idx_q <= '0;
      lk_dirty_q <= 1'b0;
      lk_data_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      lk_valid_q <= lookup_req_i;
      lk_hit_q <= lookup_req_i & lk_hit;
      lk_idx_q <= lk_idx;
      lk_dirty_q <= lookup_req_i & lk_hit & dirty_q[lk_idx];
      lk_data_q <= (lookup_req_i & lk_hit) ? data_q[lk_idx] : '0;
    end
  end
  assign lookup_valid_o = lk_valid_q;
  assign lookup_hit_o = lk_hit_q;
  assign lookup_dirty_o = lk_dirty_q;
  assign lookup_data_o = lk_data_q;
  assign wb_valid_o = wb_valid_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
  assign flush_done_o = state_q == FLUSH_DONE;
  assign occupancy_o = occ;
endmodule

// File: tb/tb_victim_cache_assoc.sv
// tb_victim_cache_assoc: directed scenarios for the victim cache with inline checks.
module tb_victim_cache_assoc;
  localparam int N = 4;
  localparam int AW = 28;
  localparam int LW = 128;
  logic clk = 1'b0;
  logic rst, lookup_req_i, extract_i, insert_valid_i, insert_dirty_i, wb_ready_i, flush_i;
  logic [AW-1:0] lookup_addr_i, insert_addr_i;
  logic [LW-1:0] insert_data_i;
  logic lookup_valid_o, lookup_hit_o, lookup_dirty_o, insert_ready_o, wb_valid_o, flush_done_o;
  logic [LW-1:0] lookup_data_o, wb_data_o;
  logic [AW-1:0] wb_addr_o;
  logic [2:0] occupancy_o;
  int total = 0;
  int bad = 0;
  victim_cache_assoc #(.VC_ENTRIES(N), .LINE_WIDTH(LW), .LINE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
    .lookup_valid_o(lookup_valid_o), .lookup_hit_o(lookup_hit_o),
    .lookup_dirty_o(lookup_dirty_o), .lookup_data_o(lookup_data_o),
    .extract_i(extract_i),
    .insert_valid_i(insert_valid_i), .insert_ready_o(insert_ready_o),
    .insert_addr_i(insert_addr_i), .insert_data_i(insert_data_i), .insert_dirty_i(insert_dirty_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .occupancy_o(occupancy_o)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_insert(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic dirty);
    insert_valid_i = 1'b1;
    insert_addr_i = a;
    insert_data_i = d;
    insert_dirty_i = dirty;
    step();
    insert_valid_i = 1'b0;
  endtask
  task automatic do_lookup(input logic [AW-1:0] a);
    lookup_req_i = 1'b1;
    lookup_addr_i = a;
    step();
    lookup_req_i = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    total++; if (lookup_valid_o !== 1'b0) begin bad++; $display("FAIL reset_lkv got=%b exp=0", lookup_valid_o); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL reset_wbv got=%b exp=0", wb_valid_o); end
    total++; if (insert_ready_o !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", insert_ready_o); end
    total++; if (occupancy_o !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
    total++; if (flush_done_o !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", flush_done_o); end
    do_lookup(28'h0000123);
    total++; if (lookup_valid_o !== 1'b1) begin bad++; $display("FAIL empty_lkv got=%b exp=1", lookup_valid_o); end
    total++; if (lookup_hit_o !== 1'b0) begin bad++; $display("FAIL empty_hit got=%b exp=0", lookup_hit_o); end
    total++; if (lookup_data_o !== '0) begin bad++; $display("FAIL empty_data got=%h exp=0", lookup_data_o); end
    step();
    total++; if (lookup_valid_o !== 1'b0) begin bad++; $display("FAIL lkv_pulse got=%b exp=0", lookup_valid_o); end
  endtask
  task automatic test_hit_extract();
    do_insert(28'h0000123, {16{8'hAA}}, 1'b0);
    total++; if (occupancy_o !== 3'd1) begin bad++; $display("FAIL ins_occ got=%0d exp=1", occupancy_o); end
    do_lookup(28'h0000123);
    total++; if (lookup_hit_o !== 1'b1) begin bad++; $display("FAIL hit got=%b exp=1", lookup_hit_o); end
    total++; if (lookup_dirty_o !== 1'b0) begin bad++; $display("FAIL hit_dirty got=%b exp=0", lookup_dirty_o); end
    total++; if (lookup_data_o !== {16{8'hAA}}) begin bad++; $display("FAIL hit_data got=%h exp=%h", lookup_data_o, {16{8'hAA}}); end
    extract_i = 1'b1;
    step();
    extract_i = 1'b0;
    total++; if (occupancy_o !== 3'd0) begin bad++; $display("FAIL ext_occ got=%0d exp=0", occupancy_o); end
    do_lookup(28'h0000123);
    total++; if (lookup_hit_o !== 1'b0) begin bad++; $display("FAIL ext_miss got=%b exp=0", lookup_hit_o); end
  endtask
  task automatic test_fifo_evict();
    wb_ready_i = 1'b0;
    do_insert(28'h10, {4{32'hD0D0_0010}}, 1'b1);
    do_insert(28'h20, {4{32'h0000_0020}}, 1'b0);
    do_insert(28'h30, {4{32'h0000_0030}}, 1'b0);
    do_insert(28'h40, {4{32'h0000_0040}}, 1'b0);
    total++; if (occupancy_o !== 3'd4) begin bad++; $display("FAIL full_occ got=%0d exp=4", occupancy_o); end
    do_insert(28'h50, {4{32'h0000_0050}}, 1'b0);
    for (int c = 0; c < 3; c++) begin
      total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL evict_wbv c=%0d got=%b exp=1", c, wb_valid_o); end
      total++; if (wb_addr_o !== 28'h10) begin bad++; $display("FAIL evict_addr c=%0d got=%h exp=10", c, wb_addr_o); end
      total++; if (wb_data_o !== {4{32'hD0D0_0010}}) begin bad++; $display("FAIL evict_data c=%0d got=%h", c, wb_data_o); end
      total++; if (insert_ready_o !== 1'b0) begin bad++; $display("FAIL evict_rdy c=%0d got=%b exp=0", c, insert_ready_o); end
      step();
    end
    total++; if (occupancy_o !== 3'd4) begin bad++; $display("FAIL evict_occ got=%0d exp=4", occupancy_o); end
    wb_ready_i = 1'b1;
    step();
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL wb_done got=%b exp=0", wb_valid_o); end
    total++; if (insert_ready_o !== 1'b1) begin bad++; $display("FAIL idle_rdy got=%b exp=1", insert_ready_o); end
    do_lookup(28'h50);
    total++; if (lookup_hit_o !== 1'b1 || lookup_data_o !== {4{32'h0000_0050}}) begin bad++; $display("FAIL new_hit got=%b/%h", lookup_hit_o, lookup_data_o); end
    do_lookup(28'h10);
    total++; if (lookup_hit_o !== 1'b0) begin bad++; $display("FAIL victim_gone got=%b exp=0", lookup_hit_o); end
  endtask
  task automatic test_reinsert();
    do_insert(28'h20, {4{32'h2222_2222}}, 1'b1);
    total++; if (occupancy_o !== 3'd4) begin bad++; $display("FAIL reins_occ got=%0d exp=4", occupancy_o); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL reins_wbv got=%b exp=0", wb_valid_o); end
    do_lookup(28'h20);
    total++; if (lookup_dirty_o !== 1'b1) begin bad++; $display("FAIL reins_dirty got=%b exp=1", lookup_dirty_o); end
    total++; if (lookup_data_o !== {4{32'h2222_2222}}) begin bad++; $display("FAIL reins_data got=%h", lookup_data_o); end
  endtask
  task automatic test_ptr_advance();
    do_insert(28'h60, {4{32'h0000_0060}}, 1'b0);
    total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL ptr1_wbv got=%b exp=1", wb_valid_o); end
    total++; if (wb_addr_o !== 28'h20) begin bad++; $display("FAIL ptr1_addr got=%h exp=20", wb_addr_o); end
    total++; if (wb_data_o !== {4{32'h2222_2222}}) begin bad++; $display("FAIL ptr1_data got=%h", wb_data_o); end
    step();
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL ptr1_done got=%b exp=0", wb_valid_o); end
  endtask
  task automatic test_flush();
    logic [AW-1:0] seen [$];
    int n;
    do_insert(28'h60, {4{32'h6666_6666}}, 1'b1);
    do_insert(28'h40, {4{32'h4444_4444}}, 1'b1);
    wb_ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n = 0;
    while (!flush_done_o && n < 40) begin
      if (wb_valid_o) seen.push_back(wb_addr_o);
      step();
      n++;
    end
    total++; if (flush_done_o !== 1'b1) begin bad++; $display("FAIL flush_timeout got=%b exp=1", flush_done_o); end
    total++; if (seen.size() !== 2) begin bad++; $display("FAIL flush_count got=%0d exp=2", seen.size()); end
    if (seen.size() == 2) begin
      total++; if (seen[0] !== 28'h60 || seen[1] !== 28'h40) begin bad++; $display("FAIL flush_order got=%h,%h exp=60,40", seen[0], seen[1]); end
    end
    total++; if (occupancy_o !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy_o); end
    step();
    total++; if (flush_done_o !== 1'b0) begin bad++; $display("FAIL flush_pulse got=%b exp=0", flush_done_o); end
    do_lookup(28'h50);
    total++; if (lookup_hit_o !== 1'b0) begin bad++; $display("FAIL flush_miss got=%b exp=0", lookup_hit_o); end
  endtask
  task automatic test_clean_flush_timing();
    int n;
    do_insert(28'h71, {4{32'h7171_7171}}, 1'b0);
    do_insert(28'h72, {4{32'h7272_7272}}, 1'b0);
    flush_i = 1'b1;
    n = 0;
    do begin
      step();
      flush_i = 1'b0;
      n++;
    end while (!flush_done_o && n < 20);
    total++; if (n !== N + 1) begin bad++; $display("FAIL clean_flush_cycles got=%0d exp=%0d", n, N + 1); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL clean_flush_wbv got=%b exp=0", wb_valid_o); end
    step();
  endtask
  task automatic test_extract_insert();
    do_insert(28'h81, {4{32'h8181_8181}}, 1'b1);
    do_insert(28'h82, {4{32'h8282_8282}}, 1'b1);
    do_insert(28'h83, {4{32'h8383_8383}}, 1'b1);
    do_insert(28'h84, {4{32'h8484_8484}}, 1'b1);
    do_lookup(28'h82);
    total++; if (lookup_hit_o !== 1'b1) begin bad++; $display("FAIL xi_hit got=%b exp=1", lookup_hit_o); end
    extract_i = 1'b1;
    do_insert(28'h90, {4{32'h9090_9090}}, 1'b1);
    extract_i = 1'b0;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL xi_wbv got=%b exp=0", wb_valid_o); end
    total++; if (occupancy_o !== 3'd4) begin bad++; $display("FAIL xi_occ got=%0d exp=4", occupancy_o); end
    do_lookup(28'h90);
    total++; if (lookup_hit_o !== 1'b1) begin bad++; $display("FAIL xi_new got=%b exp=1", lookup_hit_o); end
    do_lookup(28'h82);
    total++; if (lookup_hit_o !== 1'b0) begin bad++; $display("FAIL xi_old got=%b exp=0", lookup_hit_o); end
  endtask
  task automatic test_reset_mid_flush();
    wb_ready_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    total++; if (wb_valid_o !== 1'b1 || wb_addr_o !== 28'h81) begin bad++; $display("FAIL mid_wb got=%b/%h exp=1/81", wb_valid_o, wb_addr_o); end
    rst = 1'b1;
    step();
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rst_wbv got=%b exp=0", wb_valid_o); end
    total++; if (occupancy_o !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy_o); end
    rst = 1'b0;
    step();
    total++; if (insert_ready_o !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b exp=1", insert_ready_o); end
    do_lookup(28'h83);
    total++; if (lookup_hit_o !== 1'b0) begin bad++; $display("FAIL rst_miss83 got=%b exp=0", lookup_hit_o); end
    do_lookup(28'h90);
    total++; if (lookup_hit_o !== 1'b0) begin bad++; $display("FAIL rst_miss90 got=%b exp=0", lookup_hit_o); end
  endtask
  initial begin
    rst = 1'b1;
    lookup_req_i = 1'b0;
    lookup_addr_i = '0;
    extract_i = 1'b0;
    insert_valid_i = 1'b0;
    insert_addr_i = '0;
    insert_data_i = '0;
    insert_dirty_i = 1'b0;
    wb_ready_i = 1'b0;
    flush_i = 1'b0;
    test_reset();
    test_hit_extract();
    test_fifo_evict();
    test_reinsert();
    test_ptr_advance();
    test_flush();
    test_clean_flush_timing();
    test_extract_insert();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
